fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the main control decoder. It owns the PC, issues word requests to instruction memory over a valid/ready request channel with a response channel, and buffers returned instructions in a small FIFO. It presents {pc, inst, opcode} to the decode stage over a valid/ready handshake. It accepts redirects (branch, jal, jalr) from later stages and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word at a time from instruction memory
// and buffers returned instructions in a small FIFO for the decode stage.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [6:0]  id_opcode
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [0:0]  RUN  = 1'b0;
    localparam logic [0:0]  DROP = 1'b1;

    logic [31:0]   pc;
    logic [31:0]   tag;
    logic          outstanding;
    logic [0:0]    state;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   occ;
    logic          take;
    logic          fire;
    logic          push;
    logic          pop;

    // occ counts the slot already reserved by an in-flight request
    assign take           = id_valid && id_ready;
    assign occ            = count + {{AW{1'b0}}, outstanding};
    assign imem_req_valid = rst_n && state == RUN && !redirect_valid &&
                            (!outstanding || imem_resp_valid) && (occ < FULL || take);
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign push           = state == RUN && outstanding && imem_resp_valid && !redirect_valid;
    assign pop            = take && !redirect_valid;
    assign id_valid       = count != '0;
    assign id_pc          = id_valid ? pc_mem[rd_ptr] : '0;
    assign id_inst        = id_valid ? inst_mem[rd_ptr] : '0;
    assign id_opcode      = id_inst[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            tag         <= '0;
            outstanding <= 1'b0;
            state       <= RUN;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            // a request still in flight cannot be cancelled, so its response is dropped later
            pc          <= redirect_pc & ~32'h3;
            outstanding <= outstanding && !imem_resp_valid;
            state       <= (outstanding && !imem_resp_valid) ? DROP : RUN;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (fire) begin
                pc  <= pc + 32'd4;
                tag <= pc;
            end
            outstanding <= fire || (outstanding && !imem_resp_valid);
            if (state == DROP && imem_resp_valid) state <= RUN;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= tag;
            inst_mem[wr_ptr] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && !pop && count == FULL));
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a memory model and an in-order
// instruction-stream model of what decode must observe.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [6:0]  id_opcode;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst), .id_opcode(id_opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        nx_rst = 1'b0;
    logic        nx_rdy = 1'b1;
    logic        nx_idr = 1'b1;
    logic        nx_redir = 1'b0;
    logic [31:0] nx_rpc = '0;
    logic [31:0] exp_req = '0;
    logic [31:0] exp_pop = '0;
    logic        after_redir = 1'b0;
    logic [3:0]  pat = 4'b1001;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // one clock: apply inputs on negedge, check and advance the model 1ns later
    task automatic cycle();
        @(negedge clk);
        rst_n          = nx_rst;
        id_ready       = nx_idr;
        imem_req_ready = nx_rdy;
        redirect_valid = nx_redir;
        redirect_pc    = nx_rpc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (rst_n && q.size() != 0) begin
            if (q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(q[0].addr);
            end
        end
        #1;
        if (!rst_n) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_id_valid", id_valid, 0);
            chk("rst_id_pc", id_pc, 0);
            chk("rst_id_inst", id_inst, 0);
            q.delete();
            exp_req = 32'h0;
            exp_pop = 32'h0;
            after_redir = 1'b0;
        end else begin
            chk("req_addr", imem_req_addr, exp_req);
            if (redirect_valid) chk("req_in_redirect", imem_req_valid, 0);
            if (after_redir) chk("id_valid_after_redirect", id_valid, 0);
            chk("one_outstanding", imem_req_valid && q.size() != 0 && !imem_resp_valid, 0);
            if (id_valid) begin
                chk("id_inst", id_inst, mem_word(id_pc));
                chk("id_opcode", {25'd0, id_opcode}, {25'd0, id_inst[6:0]});
            end
            if (id_valid && id_ready && !redirect_valid) begin
                chk("pop_order", id_pc, exp_pop);
                exp_pop += 32'd4;
            end
            if (imem_resp_valid) void'(q.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                q.push_back('{imem_req_addr, cyc + lat});
                exp_req += 32'd4;
            end
            if (redirect_valid) begin
                exp_req = redirect_pc & ~32'h3;
                exp_pop = redirect_pc & ~32'h3;
            end
            after_redir = redirect_valid;
        end
        cyc++;
    endtask

    task automatic do_reset();
        nx_rst = 1'b0;
        nx_redir = 1'b0;
        cycle();
        cycle();
        nx_rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // A: streaming with 1-cycle memory
        lat = 1; nx_rdy = 1'b1; nx_idr = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c == 0) begin
                chk("A_req_valid0", imem_req_valid, 1);
                chk("A_addr0", imem_req_addr, 32'h0);
            end
            if (c < 2) chk("A_no_early_valid", id_valid, 0);
            else begin
                chk("A_id_valid", id_valid, 1);
                chk("A_id_pc", id_pc, 32'(4 * (c - 2)));
            end
            if (c == 5) begin
                chk("A_inst12", id_inst, 32'h5A5A_001F);
                chk("A_opcode12", {25'd0, id_opcode}, 32'h1F);
            end
        end
        // B: decode stalls, FIFO fills, then drains in order
        do_reset();
        for (int c = 0; c < 10; c++) begin
            nx_idr = (c >= 6);
            cycle();
            if (c == 2 || c == 5) begin
                chk("B_req_stall", imem_req_valid, 0);
                chk("B_addr_hold", imem_req_addr, 32'h8);
            end
            if (c == 5) chk("B_head", id_pc, 32'h0);
            if (c == 6) begin
                chk("B_pop0", id_pc, 32'h0);
                chk("B_req_resume", imem_req_valid, 1);
            end
            if (c == 7) chk("B_pop4", id_pc, 32'h4);
            if (c == 8) chk("B_pop8", id_pc, 32'h8);
        end
        // C: memory ready toggling 1,0,0,1
        nx_idr = 1'b1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            nx_rdy = pat[c % 4];
            cycle();
            if (c == 1) chk("C_req_valid1", imem_req_valid, 1);
            if (c >= 1 && c <= 3) chk("C_addr_hold", imem_req_addr, 32'h4);
            if (c == 4) chk("C_addr8", imem_req_addr, 32'h8);
            if (c == 5) chk("C_addr12", imem_req_addr, 32'hC);
        end
        // D: redirect while a slow request is outstanding
        lat = 3; nx_rdy = 1'b1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            nx_redir = (c == 7);
            nx_rpc = 32'h100;
            cycle();
            if (c == 6) chk("D_fire8", imem_req_addr, 32'h8);
            if (c == 7) chk("D_head4", id_pc, 32'h4);
            if (c == 8) begin
                chk("D_flushed", id_valid, 0);
                chk("D_drop_noreq", imem_req_valid, 0);
            end
            if (c == 9) chk("D_drop_noreq9", imem_req_valid, 0);
            if (c == 10) begin
                chk("D_req_new", imem_req_valid, 1);
                chk("D_addr_new", imem_req_addr, 32'h100);
                chk("D_stale_gone", id_valid, 0);
            end
            if (c == 14) begin
                chk("D_id_pc", id_pc, 32'h100);
                chk("D_id_inst", id_inst, 32'h5A5A_0113);
            end
        end
        // E: redirect coincident with a response, PC wrap, then fill FIFO
        lat = 1;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            nx_redir = (c == 1 || c == 5);
            nx_rpc = (c == 1) ? 32'h203 : 32'hFFFF_FFF9;
            nx_idr = (c < 11);
            cycle();
            if (c == 1) chk("E_no_req_redirect", imem_req_valid, 0);
            if (c == 2) begin
                chk("E_req_valid", imem_req_valid, 1);
                chk("E_addr200", imem_req_addr, 32'h200);
                chk("E_resp_dropped", id_valid, 0);
            end
            if (c == 4) chk("E_id200", id_pc, 32'h200);
            if (c == 6) chk("E_addr_top", imem_req_addr, 32'hFFFF_FFF8);
            if (c == 8) chk("E_addr_wrap", imem_req_addr, 32'h0);
            if (c == 10) chk("E_id_wrap", id_pc, 32'h0);
            if (c == 14) begin
                chk("E_full_valid", id_valid, 1);
                chk("E_full_head", id_pc, 32'h4);
                chk("E_full_noreq", imem_req_valid, 0);
            end
        end
        // F: reset mid-stream with a full FIFO
        nx_rst = 1'b0;
        cycle();
        chk("F_rst_id_valid", id_valid, 0);
        chk("F_rst_req_valid", imem_req_valid, 0);
        nx_idr = 1'b1;
        cycle();
        nx_rst = 1'b1;
        cyc = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (c == 0) begin
                chk("F_refetch_valid", imem_req_valid, 1);
                chk("F_refetch_addr", imem_req_addr, 32'h0);
            end
            if (c == 2) chk("F_id_pc0", id_pc, 32'h0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
